// File: rtl/memory_arbiter.sv
// memory_arbiter: responder side of the datapath memory-request protocol.
// Serialises the instruction fetch request (iREN) and the data read/write requests
// (dREN/dWEN) onto a single-ported RAM and returns one-cycle ihit/dhit completion pulses.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        instruction read request and address
//   ihit, iload        instruction completion pulse and fetched word
//   dREN, dWEN         data read / write request (write wins when both are set)
//   daddr, dstore      data address and write data
//   dhit, dload        data completion pulse and load data (0 for writes)
//   ramREN, ramWEN     RAM read / write enables
//   ramaddr, ramstore  RAM address and write data
//   ramload, ramstate  RAM read data and status (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
//   memerr             one-cycle pulse on RAM error (or wait timeout)
//
// Optional feature: define MEMARB_TIMEOUT_EN to abandon an access whose RAM wait count
// reaches TIMEOUT; memerr pulses and no hit is issued.

module memory_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

  localparam logic [1:0] RamAccess = 2'b10;
  localparam logic [1:0] RamError  = 2'b11;

  // Wide enough to hold STARVE_MAX (at least one bit).
  localparam int unsigned       StarveW   = $clog2(STARVE_MAX + 2);
  localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wr_q, wr_d;
  logic                tmo;
  logic                done;
  logic                dreq;

  assign done = (ramstate == RamAccess);
  assign dreq = dREN | dWEN;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [7:0] wait_q, wait_d;

  // Held at zero while idle, so every access starts counting from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q == StIdle) begin
      wait_d = '0;
    end else if (!done) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign tmo = (wait_q == TimeoutCnt);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    memerr   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iREN && (starve_q == StarveLim)) begin
          // Instruction fetch has waited behind STARVE_MAX data grants.
          state_d = StIacc;
          addr_d  = iaddr;
        end else if (dreq) begin
          state_d = StDacc;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          // iREN here implies starve_q < StarveLim, so this never overflows.
          if (iREN) begin
            starve_d = starve_q + StarveW'(1);
          end
        end else if (iREN) begin
          state_d = StIacc;
          addr_d  = iaddr;
        end
      end

      StIacc: begin
        ramaddr = addr_q;
        if (done) begin
          // Completion wins over a same-cycle abort.
          ramREN   = 1'b1;
          ihit     = 1'b1;
          iload    = ramload;
          starve_d = '0;
          state_d  = StIdle;
        end else begin
          ramREN = iREN;
          memerr = (ramstate == RamError) || tmo;
          if ((ramstate == RamError) || tmo || !iREN) begin
            state_d = StIdle;
          end
        end
      end

      StDacc: begin
        ramaddr  = addr_q;
        ramstore = wr_q ? store_q : '0;
        if (done) begin
          ramREN  = !wr_q;
          ramWEN  = wr_q;
          dhit    = 1'b1;
          dload   = wr_q ? '0 : ramload;
          state_d = StIdle;
        end else begin
          ramREN = !wr_q && dreq;
          ramWEN = wr_q && dreq;
          memerr = (ramstate == RamError) || tmo;
          if ((ramstate == RamError) || tmo || !dreq) begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a directed vector table, hand-written
// starvation / reset / timeout sequences, and randomized traffic against a
// transaction-level reference model.

module tb_memory_arbiter;

  localparam int unsigned SMAX = 4;
`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned TO     = 4;
  localparam bit          TmoOn  = 1'b1;
`else
  localparam int unsigned TO     = 255;
  localparam bit          TmoOn  = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'b00;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit, dhit, err, ren, wen;
    logic [31:0] addr, store, iload, dload;
  } outs_t;

  typedef struct {
    logic        i, dr, dw;
    logic [1:0]  rs;
    logic [31:0] ld;
    outs_t       e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: the access in flight (0 none, 1 fetch, 2 load, 3 store),
  // its captured address/data, how many data grants have overtaken a waiting
  // fetch, and how long the RAM has kept us waiting.
  int          m_kind = 0;
  logic [31:0] m_addr = '0, m_store = '0;
  int          m_streak = 0;
  int          m_waited = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic outs_t zero_outs();
    outs_t o;
    o.ihit = 0; o.dhit = 0; o.err = 0; o.ren = 0; o.wen = 0;
    o.addr = '0; o.store = '0; o.iload = '0; o.dload = '0;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o.ihit = ihit; o.dhit = dhit; o.err = memerr; o.ren = ramREN; o.wen = ramWEN;
    o.addr = ramaddr; o.store = ramstore; o.iload = iload; o.dload = dload;
    return o;
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    logic  done, live;
    o = zero_outs();
    if (m_kind == 0) return o;
    done   = (ramstate == 2'b10);
    live   = (m_kind == 1) ? iREN : (dREN | dWEN);
    o.addr = m_addr;
    o.err  = !done && ((ramstate == 2'b11) || (TmoOn && m_waited == int'(TO)));
    if (m_kind == 1) begin
      o.ren   = done || live;
      o.ihit  = done;
      o.iload = done ? ramload : '0;
    end else begin
      o.ren   = (m_kind == 2) && (done || live);
      o.wen   = (m_kind == 3) && (done || live);
      o.dhit  = done;
      o.dload = (done && m_kind == 2) ? ramload : '0;
      o.store = (m_kind == 3) ? m_store : '0;
    end
    return o;
  endfunction

  task automatic model_edge();
    logic done, live;
    done = (ramstate == 2'b10);
    if (m_kind == 0) begin
      m_waited = 0;
      if (iREN && m_streak == int'(SMAX)) begin
        m_kind = 1; m_addr = iaddr;
      end else if (dREN || dWEN) begin
        m_kind  = dWEN ? 3 : 2;
        m_addr  = daddr;
        m_store = dstore;
        if (iREN) m_streak = (m_streak + 1 > int'(SMAX)) ? int'(SMAX) : m_streak + 1;
      end else if (iREN) begin
        m_kind = 1; m_addr = iaddr;
      end
    end else begin
      live = (m_kind == 1) ? iREN : (dREN | dWEN);
      if (done) begin
        if (m_kind == 1) m_streak = 0;
        m_kind = 0;
      end else if (ramstate == 2'b11 || !live || (TmoOn && m_waited == int'(TO))) begin
        m_kind = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_addr = '0; m_store = '0; m_streak = 0; m_waited = 0;
  endtask

  task automatic compare(input outs_t a, input outs_t e, input string tag);
    chk({tag, ".ihit"},     32'(a.ihit), 32'(e.ihit));
    chk({tag, ".dhit"},     32'(a.dhit), 32'(e.dhit));
    chk({tag, ".memerr"},   32'(a.err),  32'(e.err));
    chk({tag, ".ramREN"},   32'(a.ren),  32'(e.ren));
    chk({tag, ".ramWEN"},   32'(a.wen),  32'(e.wen));
    chk({tag, ".ramaddr"},  a.addr,  e.addr);
    chk({tag, ".ramstore"}, a.store, e.store);
    chk({tag, ".iload"},    a.iload, e.iload);
    chk({tag, ".dload"},    a.dload, e.dload);
  endtask

  // One clock: drive, check against the model mid-cycle, advance the model.
  task automatic step(input logic i, input logic dr, input logic dw, input logic [1:0] rs,
                      input logic [31:0] ld, input string tag, output outs_t a);
    iREN = i; dREN = dr; dWEN = dw; ramstate = rs; ramload = ld;
    @(negedge CLK);
    a = actual();
    compare(a, model_out(), tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic vec_t v(input logic i, input logic dr, input logic dw, input logic [1:0] rs,
                             input logic [31:0] ld, input logic ih, input logic dh,
                             input logic er, input logic rn, input logic wn,
                             input logic [31:0] ad, input logic [31:0] st,
                             input logic [31:0] il, input logic [31:0] dl);
    vec_t r;
    r.i = i; r.dr = dr; r.dw = dw; r.rs = rs; r.ld = ld;
    r.e.ihit = ih; r.e.dhit = dh; r.e.err = er; r.e.ren = rn; r.e.wen = wn;
    r.e.addr = ad; r.e.store = st; r.e.iload = il; r.e.dload = dl;
    return r;
  endfunction

  initial begin
    vec_t        tbl[17];
    outs_t       a;
    logic [9:0]  ipat, dpat;
    int          r;

    // ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
    tbl[0]  = v(1,0,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[1]  = v(1,0,0,1,32'h0,        0,0,0,1,0, 32'h40,  32'h0,        32'h0,        32'h0);
    tbl[2]  = v(1,0,0,1,32'h0,        0,0,0,1,0, 32'h40,  32'h0,        32'h0,        32'h0);
    tbl[3]  = v(1,0,0,2,32'h8C220004, 1,0,0,1,0, 32'h40,  32'h0,        32'h8C220004, 32'h0);
    tbl[4]  = v(0,0,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[5]  = v(1,1,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[6]  = v(1,1,0,2,32'h11112222, 0,1,0,1,0, 32'h100, 32'h0,        32'h0,        32'h11112222);
    tbl[7]  = v(1,0,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[8]  = v(1,0,0,2,32'h33334444, 1,0,0,1,0, 32'h40,  32'h0,        32'h33334444, 32'h0);
    tbl[9]  = v(0,1,1,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[10] = v(0,1,1,2,32'h55555555, 0,1,0,0,1, 32'h100, 32'hDEADBEEF, 32'h0,        32'h0);
    tbl[11] = v(0,1,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[12] = v(0,1,0,3,32'h0,        0,0,1,1,0, 32'h100, 32'h0,        32'h0,        32'h0);
    tbl[13] = v(0,1,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[14] = v(0,1,0,1,32'h0,        0,0,0,1,0, 32'h100, 32'h0,        32'h0,        32'h0);
    tbl[15] = v(0,0,0,1,32'h0,        0,0,0,0,0, 32'h100, 32'h0,        32'h0,        32'h0);
    tbl[16] = v(0,0,0,0,32'h0,        0,0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0);

    // Reset state
    #2;
    compare(actual(), zero_outs(), "reset");
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();

    // Directed table
    iaddr = 32'h40; daddr = 32'h100; dstore = 32'hDEADBEEF;
    for (int k = 0; k < 17; k++) begin
      iREN = tbl[k].i; dREN = tbl[k].dr; dWEN = tbl[k].dw;
      ramstate = tbl[k].rs; ramload = tbl[k].ld;
      @(negedge CLK);
      compare(actual(), tbl[k].e, $sformatf("vec%0d", k));
      @(posedge CLK);
      model_edge();
      #1;
    end

    // Starvation: fetch and load held, RAM answers at once; four loads then a fetch.
    ipat = '0; dpat = '0;
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 0, 2'b10, 32'hA0 + 32'(k), "starve", a);
      ipat = {ipat[8:0], a.ihit};
      dpat = {dpat[8:0], a.dhit};
    end
    chk("starve_ihits", 32'(ipat), 32'(10'b0000000001));
    chk("starve_dhits", 32'(dpat), 32'(10'b0101010100));
    step(0, 0, 0, 2'b00, 32'h0, "starve_idle", a);

    // Reset asserted in the middle of a fetch
    iaddr = 32'h80;
    step(1, 0, 0, 2'b01, 32'h0, "rst_grant", a);
    step(1, 0, 0, 2'b01, 32'h0, "rst_busy", a);
    #2 nRST = 1'b0;
    #1 compare(actual(), zero_outs(), "rst_mid");
    model_reset();
    iREN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;

`ifdef MEMARB_TIMEOUT_EN
    // RAM held BUSY: memerr on the fifth access cycle (after four waits), no hit.
    step(1, 0, 0, 2'b01, 32'h0, "tmo_grant", a);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 2'b01, 32'h0, "tmo_wait", a);
      chk("tmo_wait_err", 32'(a.err), 32'(0));
    end
    step(1, 0, 0, 2'b01, 32'h0, "tmo_fire", a);
    chk("tmo_fire_err", 32'(a.err), 32'(1));
    chk("tmo_fire_hit", 32'(a.ihit), 32'(0));
    step(0, 0, 0, 2'b00, 32'h0, "tmo_idle", a);
    step(0, 0, 0, 2'b00, 32'h0, "tmo_idle2", a);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [1:0] rs;
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      r = $urandom_range(0, 9);
      rs = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      step(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 5) == 0, rs, $urandom,
           $sformatf("rnd%0d", k), a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder side of the datapath memory-request protocol.
- Accepts the always-on instruction fetch request (iREN) and the data read/write requests (dREN/dWEN) raised by the datapath's request logic.
- Serialises them onto the single-ported RAM and returns one-cycle ihit/dhit completion pulses with load data.
- Sits between the datapath/request logic and the RAM model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before an instruction grant is forced.
- TIMEOUT, 255, RAM wait-cycle limit (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- ihit  out  1  instruction access complete, 1-cycle pulse.
- iload  out  DATA_W  instruction word, valid when ihit=1.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  data access complete, 1-cycle pulse.
- dload  out  DATA_W  read data, valid when dhit=1.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  00=FREE, 01=BUSY, 10=ACCESS, 11=ERROR.
- memerr  out  1  1-cycle pulse on RAM error (or timeout).

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset nRST is asynchronous, active-low.
  - Reset state is IDLE, starve counter 0, latched address/data 0.
  - All outputs are 0 in reset: ihit, dhit, memerr, ramREN, ramWEN, ramaddr, ramstore, iload, dload.
- States: IDLE, IACC, DACC.
- IDLE:
  - ramREN=ramWEN=0.
  - Grant priority: data over instruction, unless the starve counter equals STARVE_MAX and iREN=1, in which case the instruction is granted.
  - On grant, latch address and (for data) dstore and op, then enter IACC or DACC next edge.
  - If dREN and dWEN are both 1, the write wins.
- IACC:
  - ramREN=1, ramaddr=latched iaddr.
  - On ramstate=ACCESS (same cycle): ihit=1, iload=ramload, next state IDLE, starve counter cleared.
- DACC:
  - Read: ramREN=1. Write: ramWEN=1, ramstore=latched dstore. ramaddr=latched daddr.
  - On ACCESS: dhit=1; dload=ramload for reads (0 for writes); next state IDLE.
  - Starve counter increments, saturating at STARVE_MAX, only if iREN=1 at the grant.
- Hit outputs are combinational from state and ramstate; exactly one hit pulse per access; minimum access latency is 2 cycles (grant edge, then ACCESS).
- FREE/BUSY in an access state: hold state and RAM outputs unchanged.
- ERROR in an access state: memerr=1 for that cycle, no hit, return to IDLE; the request is re-arbitrated if still asserted.
- Abort: in DACC, if dREN=dWEN=0, or in IACC, if iREN=0, before ACCESS is seen, drop RAM enables combinationally and return to IDLE; no hit is issued.
- Simultaneous ACCESS and abort in the same cycle: the hit is issued (completion wins).
- After any hit there is always one IDLE cycle; requesters deassert within that cycle.
- Reset asserted mid-access: immediate return to IDLE, all enables low, no hit.

Optional Feature:
- Macro MEMARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to IACC/DACC and increments each cycle ramstate≠ACCESS.
  - When the counter reaches TIMEOUT: memerr pulses, no hit is issued, state returns to IDLE.
- Undefined: no counter; the block waits indefinitely for ACCESS or ERROR.

Test Plan:
- iREN=1, iaddr=0x40; RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ihit pulses once, iload=0x8C220004, ramREN high 3 cycles, then one IDLE cycle.
- iREN=1 and dREN=1 (daddr=0x100) simultaneously -> DACC granted first, dhit then ihit; ramaddr=0x100 before 0x40.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF, immediate ACCESS -> ramWEN=1, ramstore=0xDEADBEEF, dhit=1, dload=0; dREN+dWEN both set -> write performed.
- Back-to-back data requests with iREN held 1, STARVE_MAX=4 -> after 4 dhits the 5th grant is an instruction (ihit) despite a pending data request.
- ramstate=ERROR during DACC -> memerr=1 one cycle, dhit=0, state IDLE; dREN dropped mid-BUSY -> RAM enables low the same cycle, no dhit.
- MEMARB_TIMEOUT_EN defined, TIMEOUT=4, RAM held BUSY -> memerr pulses after 4 wait cycles, no hit; nRST low mid-IACC -> all outputs 0 immediately.
